// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage and the DMA loader.
// CPU has priority; a starvation guard and a bounded lock (burst) mode protect the DMA.
module mem_port_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 24,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);
    localparam int WCW = $clog2(STARVE_LIMIT + 1);
    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic {ARB, LOCK} state_t;

    state_t         state_reg, state_next;
    logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [LCW-1:0] lock_cnt_reg, lock_cnt_next;
    logic           cpu_rvalid_reg, dma_rvalid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ARB;
            wait_cnt_reg   <= '0;
            lock_cnt_reg   <= '0;
            cpu_rvalid_reg <= 1'b0;
            dma_rvalid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            cpu_rvalid_reg <= cpu_gnt && !cpu_we;
            dma_rvalid_reg <= dma_gnt && !dma_we;
        end
    end

    // No RAM access is issued while reset is held, even if requests are high.
    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        cpu_gnt       = 1'b0;
        dma_gnt       = 1'b0;
        if (!rst) begin
            case (state_reg)
                ARB: begin
                    if (dma_req && (!cpu_req || wait_cnt_reg == WCW'(STARVE_LIMIT))) begin
                        dma_gnt = 1'b1;
                        if (dma_lock) begin
                            state_next    = LOCK;
                            lock_cnt_next = LCW'(1);
                        end
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end
                end
                LOCK: begin
                    if (cpu_req && lock_cnt_reg == LCW'(LOCK_MAX)) begin
                        cpu_gnt       = 1'b1;
                        state_next    = ARB;
                        lock_cnt_next = '0;
                    end else if (dma_req && dma_lock) begin
                        dma_gnt = 1'b1;
                        if (lock_cnt_reg != LCW'(LOCK_MAX)) begin
                            lock_cnt_next = lock_cnt_reg + LCW'(1);
                        end
                    end else begin
                        // Lock dropped: a still-requesting DMA gets one final beat.
                        dma_gnt       = dma_req;
                        state_next    = ARB;
                        lock_cnt_next = '0;
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (!dma_req || dma_gnt) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WCW'(STARVE_LIMIT)) begin
            wait_cnt_next = wait_cnt_reg + WCW'(1);
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign mem_en     = cpu_gnt | dma_gnt;
    assign cpu_stall  = cpu_req && !cpu_gnt;
    assign locked     = (state_reg == LOCK);
    assign cpu_rvalid = cpu_rvalid_reg;
    assign dma_rvalid = dma_rvalid_reg;
    assign cpu_rdata  = cpu_rvalid_reg ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid_reg ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle-level reference
// model kept as plain integers, with a bench-side RAM and shadow copy for read data.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 24;
    localparam int SL = 4;
    localparam int LM = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we, locked;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    // Bench RAM driven by the DUT; idle cycles put garbage on mem_rdata.
    logic [DW-1:0] ram    [0:65535];
    logic [DW-1:0] shadow [0:65535];
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
        else                   mem_rdata <= DW'($urandom);
        if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state
    int            m_wait, m_beats;
    bit            m_burst, m_crv, m_drv;
    logic [DW-1:0] m_crd, m_drd;
    bit            e_cg, e_dg;
    // Observed values from the last step
    logic          o_cg, o_dg, o_stall, o_lk, o_we, o_crv, o_drv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_beats = 0; m_burst = 0; m_crv = 0; m_drv = 0;
        m_crd = '0; m_drd = '0;
    endtask

    task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic dr, input logic dw, input logic dl,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
        #1;
        e_cg = 0; e_dg = 0;
        if (!m_burst) begin
            e_dg = dr && (!cr || m_wait >= SL);
            e_cg = cr && !e_dg;
        end else if (cr && m_beats >= LM) begin
            e_cg = 1;
        end else begin
            e_dg = dr;
        end
        ea = e_cg ? ca : (e_dg ? da : '0);
        ed = e_cg ? cd : (e_dg ? dd : '0);
        check("cpu_gnt",    32'(cpu_gnt),    32'(e_cg));
        check("dma_gnt",    32'(dma_gnt),    32'(e_dg));
        check("cpu_stall",  32'(cpu_stall),  32'(cr && !e_cg));
        check("locked",     32'(locked),     32'(m_burst));
        check("mem_en",     32'(mem_en),     32'(e_cg || e_dg));
        check("mem_we",     32'(mem_we),     32'(e_cg ? cw : (e_dg ? dw : 1'b0)));
        check("mem_addr",   32'(mem_addr),   32'(ea));
        check("mem_wdata",  32'(mem_wdata),  32'(ed));
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
        check("cpu_rdata",  32'(cpu_rdata),  32'(m_crv ? m_crd : '0));
        check("dma_rvalid", 32'(dma_rvalid), 32'(m_drv));
        check("dma_rdata",  32'(dma_rdata),  32'(m_drv ? m_drd : '0));
        o_cg = cpu_gnt; o_dg = dma_gnt; o_stall = cpu_stall; o_lk = locked;
        o_we = mem_we; o_crv = cpu_rvalid; o_drv = dma_rvalid;
        $display("[TB] cyc=%0d cpu_req=%0b cpu_gnt=%0b dma_req=%0b dma_gnt=%0b locked=%0b mem_we=%0b mem_addr=%h",
                 cyc, cr, cpu_gnt, dr, dma_gnt, locked, mem_we, mem_addr);
        @(posedge clk);
        m_crv = e_cg && !cw;
        if (m_crv) m_crd = shadow[ca];
        m_drv = e_dg && !dw;
        if (m_drv) m_drd = shadow[da];
        if (e_cg && cw) shadow[ca] = cd;
        if (e_dg && dw) shadow[da] = dd;
        m_wait = (dr && !e_dg) ? ((m_wait + 1 > SL) ? SL : m_wait + 1) : 0;
        if (!m_burst) begin
            if (e_dg && dl) begin m_burst = 1; m_beats = 1; end
        end else if (e_cg || !dr || !dl) begin
            m_burst = 0; m_beats = 0;
        end else begin
            m_beats = (m_beats + 1 > LM) ? LM : m_beats + 1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        logic          cr, cw, dr, dw, dl, cpu_done;
        logic [AW-1:0] ca, da;
        logic [DW-1:0] cd, dd;
        int            beat, c;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = DW'($urandom);
            shadow[i] = ram[i];
        end
        ram[16'h0010] = 24'hABCDEF;
        shadow[16'h0010] = 24'hABCDEF;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_locked", 32'(locked), 32'(0));
        check("rst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'(0));
        check("rst_mem_en", 32'(mem_en), 32'(0));
        rst = 1'b0;
        model_reset();

        // CPU-only read
        step(1, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
        check("t1_gnt", 32'({o_cg, o_stall}), 32'(2));
        check("t1_rdata", 32'(cpu_rdata), 32'(24'hABCDEF));
        idle();

        // Contention without lock: 4 CPU grants then one DMA grant, repeating
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 16'h0040, '0, 1, 0, 0, 16'h0200, '0);
            check("cont_dma", 32'(o_dg), 32'(i % 5 == 4));
            check("cont_stall", 32'(o_stall), 32'(i % 5 == 4));
        end
        idle();

        // Locked DMA burst with CPU arriving on beat 3
        beat = 0; c = 0; cpu_done = 0;
        while (beat < 20 && c < 60) begin
            c++;
            cr = (c >= 3) && !cpu_done;
            step(cr, 0, 16'h0030, '0, 1, 1, 1, 16'h0100 + AW'(beat), 24'h500000 + DW'(beat));
            if (o_dg) beat++;
            if (o_cg) cpu_done = 1;
            if (c <= 16) check("burst_dma", 32'(o_dg), 32'(1));
            if (c >= 3 && c <= 16) check("burst_stall", 32'(o_stall), 32'(1));
            if (c == 17) check("burst_cpu", 32'(o_cg), 32'(1));
            if (c == 18) check("burst_unlock", 32'(o_lk), 32'(0));
        end
        check("burst_beats", 32'(beat), 32'(20));
        idle();

        // Lock released on beat 5 while still requesting
        for (int b = 1; b <= 5; b++) begin
            step(0, 0, '0, '0, 1, 1, (b < 5), 16'h0300 + AW'(b), 24'h0A0000 + DW'(b));
        end
        check("rel_beat5", 32'({o_dg, o_lk}), 32'(3));
        idle();
        check("rel_unlocked", 32'(o_lk), 32'(0));

        // Read/write interleave
        step(1, 0, 16'h0020, '0, 0, 0, 0, '0, '0);
        check("il_n_we", 32'(o_we), 32'(0));
        step(0, 0, '0, '0, 1, 1, 0, 16'h0021, 24'h123456);
        check("il_n1", 32'({o_we, o_crv, o_drv}), 32'(6));
        idle();
        check("il_n2", 32'({o_we, o_crv, o_drv}), 32'(0));
        step(1, 0, 16'h0021, '0, 0, 0, 0, '0, '0);
        check("il_readback", 32'(cpu_rdata), 32'(24'h123456));
        idle();

        // Async reset during LOCK with a DMA read outstanding
        step(0, 0, '0, '0, 1, 0, 1, 16'h0400, '0);
        check("ar_pre", 32'({locked, dma_rvalid}), 32'(3));
        cpu_req = 1;
        #2 rst = 1'b1;
        #1;
        check("ar_locked", 32'(locked), 32'(0));
        check("ar_gnts", 32'({cpu_gnt, dma_gnt, mem_en}), 32'(0));
        check("ar_rvalid", 32'(dma_rvalid), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 0, 16'h0050, '0, 1, 0, 0, 16'h0500, '0);
        check("ar_cpu_first", 32'({o_cg, o_dg}), 32'(2));

        // Randomized traffic; a denied requester holds its request stable
        cr = 0; cw = 0; ca = '0; cd = '0; dr = 0; dw = 0; dl = 0; da = '0; dd = '0;
        e_cg = 0; e_dg = 0;
        for (int n = 0; n < 300; n++) begin
            if (!(cr && !e_cg)) begin
                cr = ($urandom_range(0, 99) < 60);
                cw = 1'($urandom);
                ca = AW'($urandom_range(0, 63));
                cd = DW'($urandom);
            end
            if (!(dr && !e_dg)) begin
                dr = ($urandom_range(0, 99) < 60);
                dw = 1'($urandom);
                dl = ($urandom_range(0, 99) < 70);
                da = AW'($urandom_range(0, 63));
                dd = DW'($urandom);
            end
            step(cr, cw, ca, cd, dr, dw, dl, da, dd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
